// File: rtl/hazard_fwd_ctrl_pkg.sv
// Shared pipeline types for the hazard/forwarding scoreboard.
// Entry fields are sized for the widest supported register address.
package pipe_pkg;

    localparam int RA_MAX      = 8;
    localparam int SEL_RF      = 0;
    localparam int STAGES_DEF  = 3;
    localparam int ALU_RDY_DEF = 2;
    localparam int LD_RDY_DEF  = 3;

    typedef struct packed {
        logic              vld;
        logic [RA_MAX-1:0] rd;
        logic              wen;
        logic              ld;
        logic [RA_MAX-1:0] rs;
        logic [RA_MAX-1:0] rt;
    } sb_entry_t;

    // First stage index whose result can be forwarded.
    function automatic int rdy_stage(
        input logic ld,
        input int   alu_rdy,
        input int   ld_rdy
    );
        return ld ? ld_rdy : alu_rdy;
    endfunction

endpackage

// File: rtl/hazard_fwd_ctrl_if.sv
// Decode-side request and pipeline-control response of the hazard unit.
// master = controller/decode side, slave = hazard_fwd_ctrl.
interface hazard_fwd_ctrl_if #(
    parameter int RA_W  = 5,
    parameter int SEL_W = 2,
    parameter int CNT_W = 16
);

    logic            id_valid;
    logic [RA_W-1:0] id_rs;
    logic [RA_W-1:0] id_rt;
    logic            id_use_rs;
    logic            id_use_rt;
    logic [RA_W-1:0] id_rd;
    logic            id_reg_write;
    logic            id_mem_read;
    logic            flush;
    logic            hold;

    logic             pc_write;
    logic             ifid_write;
    logic             id_bubble;
    logic [SEL_W-1:0] fwd_a;
    logic [SEL_W-1:0] fwd_b;
    logic [CNT_W-1:0] stall_cnt;

    modport master (
        output id_valid, id_rs, id_rt, id_use_rs, id_use_rt,
        output id_rd, id_reg_write, id_mem_read, flush, hold,
        input  pc_write, ifid_write, id_bubble,
        input  fwd_a, fwd_b, stall_cnt
    );

    modport slave (
        input  id_valid, id_rs, id_rt, id_use_rs, id_use_rt,
        input  id_rd, id_reg_write, id_mem_read, flush, hold,
        output pc_write, ifid_write, id_bubble,
        output fwd_a, fwd_b, stall_cnt
    );

endinterface

// File: rtl/hazard_sb_stage.sv
// One scoreboard slot: loads d each unfrozen cycle, or an
// empty slot when bubble is set.
module hazard_sb_stage
    import pipe_pkg::*;
(
    input  logic      clk,
    input  logic      rst,
    input  logic      hold,
    input  logic      bubble,
    input  sb_entry_t d,
    output sb_entry_t q
);

    always_ff @(posedge clk) begin
        if (!rst) begin
            q <= '0;
        end else if (!hold) begin
            q <= bubble ? '0 : d;
        end
    end

endmodule

// File: rtl/hazard_fwd_ctrl.sv
// Load-use stall, flush/hold arbitration and EX forward selection
// driven from a shift-register scoreboard of in-flight instructions.
module hazard_fwd_ctrl
    import pipe_pkg::*;
#(
    parameter int RA_W    = 5,
    parameter int STAGES  = STAGES_DEF,
    parameter int ALU_RDY = ALU_RDY_DEF,
    parameter int LD_RDY  = LD_RDY_DEF,
    parameter int SEL_W   = $clog2(STAGES + 1),
    parameter int CNT_W   = 16
) (
    input logic              clk,
    input logic              rst,
    hazard_fwd_ctrl_if.slave hz
);

    sb_entry_t        sb [1:STAGES];
    sb_entry_t        id_ent;
    logic [STAGES:1]  live;
    logic             hazard;
    logic             stall;
    logic             load_new;
    logic [SEL_W-1:0] fwd_a;
    logic [SEL_W-1:0] fwd_b;
    logic [CNT_W-1:0] cnt;

    always_comb begin
        id_ent     = '0;
        id_ent.vld = 1'b1;
        id_ent.wen = hz.id_reg_write;
        id_ent.ld  = hz.id_mem_read;
        id_ent.rd  = RA_MAX'(hz.id_rd);
        id_ent.rs  = RA_MAX'(hz.id_rs);
        id_ent.rt  = RA_MAX'(hz.id_rt);
    end

    genvar k;
    generate
        for (k = 1; k <= STAGES; k++) begin : g_sb
            if (k == 1) begin : g_head
                hazard_sb_stage u_sb (
                    .clk    (clk),
                    .rst    (rst),
                    .hold   (hz.hold),
                    .bubble (!load_new),
                    .d      (id_ent),
                    .q      (sb[k])
                );
            end else begin : g_tail
                hazard_sb_stage u_sb (
                    .clk    (clk),
                    .rst    (rst),
                    .hold   (hz.hold),
                    .bubble (1'b0),
                    .d      (sb[k-1]),
                    .q      (sb[k])
                );
            end
        end
    endgenerate

    // r0 writers never produce a hazard or a forward.
    always_comb begin
        for (int i = 1; i <= STAGES; i++) begin
            live[i] = sb[i].vld & sb[i].wen
                    & (sb[i].rd[RA_W-1:0] != '0);
        end
    end

    always_comb begin
        hazard = 1'b0;
        for (int i = 1; i <= STAGES; i++) begin
            if (live[i] &&
                (i + 1 < rdy_stage(sb[i].ld, ALU_RDY, LD_RDY))) begin
                if (hz.id_use_rs && sb[i].rd == id_ent.rs)
                    hazard = 1'b1;
                if (hz.id_use_rt && sb[i].rd == id_ent.rt)
                    hazard = 1'b1;
            end
        end
    end

    assign stall    = hz.id_valid & ~hz.flush & ~hz.hold & hazard;
    assign load_new = hz.id_valid & ~hz.flush & ~stall;

    // Walk oldest to youngest so the youngest ready producer wins.
    always_comb begin
        fwd_a = SEL_W'(SEL_RF);
        fwd_b = SEL_W'(SEL_RF);
        for (int i = STAGES; i >= 1; i--) begin
            if (live[i] &&
                (i >= rdy_stage(sb[i].ld, ALU_RDY, LD_RDY))) begin
                if (sb[i].rd == sb[1].rs)
                    fwd_a = SEL_W'(i);
                if (sb[i].rd == sb[1].rt)
                    fwd_b = SEL_W'(i);
            end
        end
        if (!sb[1].vld) begin
            fwd_a = SEL_W'(SEL_RF);
            fwd_b = SEL_W'(SEL_RF);
        end
    end

    assign hz.fwd_a = fwd_a;
    assign hz.fwd_b = fwd_b;

    always_comb begin
        hz.pc_write   = 1'b1;
        hz.ifid_write = 1'b1;
        hz.id_bubble  = 1'b0;
        unique case (1'b1)
            hz.hold: begin
                hz.pc_write   = 1'b0;
                hz.ifid_write = 1'b0;
            end
            hz.flush & ~hz.hold: begin
                hz.id_bubble  = 1'b1;
            end
            stall: begin
                hz.pc_write   = 1'b0;
                hz.ifid_write = 1'b0;
                hz.id_bubble  = 1'b1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            cnt <= '0;
        end else if (stall && (cnt != '1)) begin
            cnt <= cnt + CNT_W'(1);
        end
    end

    assign hz.stall_cnt = cnt;

endmodule
